// File: rtl/msrh_dcache_upd_arb.sv
// msrh_dcache_upd_arb: arbitrates refills and store writes onto the L1D update port.
// Refills queue in a small FIFO; same-line stores wait behind them; stores cannot starve forever.
module msrh_dcache_upd_arb #(
    parameter int PADDR_W    = 56,
    parameter int DATA_W     = 512,
    parameter int RBUF_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_refill_valid,
    input  logic [PADDR_W-1:0]    i_refill_paddr,
    input  logic [DATA_W-1:0]     i_refill_data,
    output logic                  o_refill_buf_full,
    input  logic                  i_st_valid,
    output logic                  o_st_ready,
    input  logic [PADDR_W-1:0]    i_st_paddr,
    input  logic [DATA_W-1:0]     i_st_data,
    input  logic [DATA_W/8-1:0]   i_st_be,
    output logic                  o_upd_valid,
    output logic [PADDR_W-1:0]    o_upd_paddr,
    output logic [DATA_W-1:0]     o_upd_data,
    output logic [DATA_W/8-1:0]   o_upd_be,
    output logic                  o_upd_src,
    output logic                  o_err_overflow
);
    localparam int LSB = $clog2(DATA_W/8);
    localparam int PW  = $clog2(RBUF_DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW  = $clog2(STARVE_MAX + 1);

    logic [PADDR_W-1:0] paddr_q [RBUF_DEPTH];
    logic [DATA_W-1:0]  data_q  [RBUF_DEPTH];
    logic [PW-1:0]      head, tail, off;
    logic [CW-1:0]      count, count_nx;
    logic [SW-1:0]      starve;
    logic               empty, full, r_valid, hit, s_ok, s_win, r_win, push, pop, overflow;
    logic [PADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0]  r_data;

    always_comb begin
        empty   = count == '0;
        full    = count == CW'(RBUF_DEPTH);
        r_valid = !empty || i_refill_valid;
        r_paddr = empty ? i_refill_paddr : paddr_q[head];
        r_data  = empty ? i_refill_data : data_q[head];
        hit     = i_refill_valid && (i_refill_paddr[PADDR_W-1:LSB] == i_st_paddr[PADDR_W-1:LSB]);
        off     = '0;
        for (int i = 0; i < RBUF_DEPTH; i++) begin
            off = PW'(i) - head;
            if ({1'b0, off} < count && paddr_q[i][PADDR_W-1:LSB] == i_st_paddr[PADDR_W-1:LSB])
                hit = 1'b1;
        end
        s_ok     = i_st_valid && !hit;
        s_win    = s_ok && (!r_valid || starve == SW'(STARVE_MAX));
        r_win    = r_valid && !s_win;
        pop      = r_win && !empty;
        // an empty-FIFO refill that wins goes straight out and is never stored
        push     = i_refill_valid && !(empty && r_win) && (!full || pop);
        overflow = i_refill_valid && full && !pop;
        count_nx = count + CW'(push) - CW'(pop);
    end

    assign o_st_ready = s_win;

    always_ff @(posedge i_clk) begin
        if (push) begin
            paddr_q[tail] <= i_refill_paddr;
            data_q[tail]  <= i_refill_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            starve            <= '0;
            o_refill_buf_full <= 1'b0;
            o_err_overflow    <= 1'b0;
            o_upd_valid       <= 1'b0;
            o_upd_paddr       <= '0;
            o_upd_data        <= '0;
            o_upd_be          <= '0;
            o_upd_src         <= 1'b0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count             <= count_nx;
            o_refill_buf_full <= count_nx == CW'(RBUF_DEPTH);
            if (overflow) o_err_overflow <= 1'b1;
            // a blocked store holds its count; only unblocked losses move it
            if (!i_st_valid || s_win) starve <= '0;
            else if (s_ok && starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
            o_upd_valid <= r_win || s_win;
            if (s_win) begin
                o_upd_paddr <= i_st_paddr;
                o_upd_data  <= i_st_data;
                o_upd_be    <= i_st_be;
                o_upd_src   <= 1'b1;
            end else if (r_win) begin
                o_upd_paddr <= r_paddr;
                o_upd_data  <= r_data;
                o_upd_be    <= '1;
                o_upd_src   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_msrh_dcache_upd_arb.sv
// tb_msrh_dcache_upd_arb: directed bench for the dcache update arbiter.
module tb_msrh_dcache_upd_arb;
    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_refill_valid;
    logic [55:0]  i_refill_paddr;
    logic [511:0] i_refill_data;
    logic         o_refill_buf_full;
    logic         i_st_valid;
    logic         o_st_ready;
    logic [55:0]  i_st_paddr;
    logic [511:0] i_st_data;
    logic [63:0]  i_st_be;
    logic         o_upd_valid;
    logic [55:0]  o_upd_paddr;
    logic [511:0] o_upd_data;
    logic [63:0]  o_upd_be;
    logic         o_upd_src;
    logic         o_err_overflow;
    int           total = 0;
    int           bad = 0;

    msrh_dcache_upd_arb dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_refill_valid(i_refill_valid), .i_refill_paddr(i_refill_paddr),
        .i_refill_data(i_refill_data), .o_refill_buf_full(o_refill_buf_full),
        .i_st_valid(i_st_valid), .o_st_ready(o_st_ready), .i_st_paddr(i_st_paddr),
        .i_st_data(i_st_data), .i_st_be(i_st_be),
        .o_upd_valid(o_upd_valid), .o_upd_paddr(o_upd_paddr), .o_upd_data(o_upd_data),
        .o_upd_be(o_upd_be), .o_upd_src(o_upd_src), .o_err_overflow(o_err_overflow)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [511:0] mk(input logic [55:0] a);
        return {16{a[31:0] ^ 32'hC0DE_0000}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_upd(input string tag, input logic [55:0] pa, input logic src,
                           input logic [63:0] be, input logic [511:0] data);
        chk({tag, ".valid"}, 512'(o_upd_valid), 512'd1);
        chk({tag, ".paddr"}, 512'(o_upd_paddr), 512'(pa));
        chk({tag, ".src"}, 512'(o_upd_src), 512'(src));
        chk({tag, ".be"}, 512'(o_upd_be), 512'(be));
        chk({tag, ".data"}, o_upd_data, data);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic refill(input logic v, input logic [55:0] pa);
        i_refill_valid = v;
        i_refill_paddr = pa;
        i_refill_data  = mk(pa);
    endtask

    task automatic store(input logic v, input logic [55:0] pa, input logic [63:0] be);
        i_st_valid = v;
        i_st_paddr = pa;
        i_st_data  = ~mk(pa);
        i_st_be    = be;
    endtask

    initial begin
        logic [55:0] pa;
        i_reset = 1'b1;
        refill(1'b0, '0);
        store(1'b0, '0, '0);
        #12;
        chk("rst.valid", 512'(o_upd_valid), 512'd0);
        chk("rst.full", 512'(o_refill_buf_full), 512'd0);
        chk("rst.ovf", 512'(o_err_overflow), 512'd0);
        chk("rst.paddr", 512'(o_upd_paddr), 512'd0);
        i_reset = 1'b0;
        tick();
        chk("idle.valid", 512'(o_upd_valid), 512'd0);

        refill(1'b1, 56'h1000);
        #1 chk("r_only.ready", 512'(o_st_ready), 512'd0);
        tick();
        refill(1'b0, '0);
        chk_upd("r_only", 56'h1000, 1'b0, '1, mk(56'h1000));
        chk("r_only.full", 512'(o_refill_buf_full), 512'd0);
        tick();
        chk("r_only.empty", 512'(o_upd_valid), 512'd0);
        chk("r_only.hold", 512'(o_upd_paddr), 512'h1000);

        store(1'b1, 56'h2040, 64'h00FF);
        #1 chk("s_only.ready", 512'(o_st_ready), 512'd1);
        tick();
        store(1'b0, '0, '0);
        chk_upd("s_only", 56'h2040, 1'b1, 64'h00FF, ~mk(56'h2040));

        // four refill wins, then the held store is forced through
        store(1'b1, 56'h5000, 64'hF0F0);
        for (int i = 0; i < 5; i++) begin
            refill(1'b1, 56'h4000 + 56'(i * 'h40));
            #1 chk("starve.ready", 512'(o_st_ready), 512'(i == 4));
            tick();
            if (i == 4) chk_upd("starve.st", 56'h5000, 1'b1, 64'hF0F0, ~mk(56'h5000));
            else chk_upd("starve.r", 56'h4000 + 56'(i * 'h40), 1'b0, '1, mk(56'h4000 + 56'(i * 'h40)));
        end
        chk("starve.ovf", 512'(o_err_overflow), 512'd0);
        chk("starve.full", 512'(o_refill_buf_full), 512'd0);

        // 0x4100 is buffered; 0x3000 queues behind it and blocks the 0x3008 store
        store(1'b1, 56'h3008, 64'h1);
        refill(1'b1, 56'h3000);
        #1 chk("ord.readyA", 512'(o_st_ready), 512'd0);
        tick();
        chk_upd("ord.head", 56'h4100, 1'b0, '1, mk(56'h4100));
        refill(1'b0, '0);
        #1 chk("ord.readyB", 512'(o_st_ready), 512'd0);
        tick();
        chk_upd("ord.r3000", 56'h3000, 1'b0, '1, mk(56'h3000));
        #1 chk("ord.readyC", 512'(o_st_ready), 512'd1);
        tick();
        store(1'b0, '0, '0);
        chk_upd("ord.st", 56'h3008, 1'b1, 64'h1, ~mk(56'h3008));

        // stores win at i=4,9,14; the FIFO fills at 9, replaces 10-13, overflows at 14
        store(1'b1, 56'h7000, 64'hFFFF);
        for (int i = 0; i < 15; i++) begin
            refill(1'b1, 56'h8000 + 56'(i * 'h40));
            #1 chk("ovf.ready", 512'(o_st_ready), 512'(i == 4 || i == 9 || i == 14));
            tick();
            if (i == 4 || i == 9 || i == 14) chk_upd("ovf.st", 56'h7000, 1'b1, 64'hFFFF, ~mk(56'h7000));
            else begin
                pa = 56'h8000 + 56'((i < 4 ? i : i < 9 ? i - 1 : i - 2) * 'h40);
                chk_upd("ovf.r", pa, 1'b0, '1, mk(pa));
            end
            chk("ovf.full", 512'(o_refill_buf_full), 512'(i >= 9));
            chk("ovf.err", 512'(o_err_overflow), 512'(i == 14));
        end

        // two refills are buffered here; async reset must clear outputs at once
        refill(1'b0, '0);
        store(1'b0, '0, '0);
        #1 chk("ovf.sticky", 512'(o_err_overflow), 512'd1);
        i_reset = 1'b1;
        #1;
        chk("mrst.valid", 512'(o_upd_valid), 512'd0);
        chk("mrst.paddr", 512'(o_upd_paddr), 512'd0);
        chk("mrst.data", o_upd_data, 512'd0);
        chk("mrst.be", 512'(o_upd_be), 512'd0);
        chk("mrst.src", 512'(o_upd_src), 512'd0);
        chk("mrst.full", 512'(o_refill_buf_full), 512'd0);
        chk("mrst.ovf", 512'(o_err_overflow), 512'd0);
        chk("mrst.ready", 512'(o_st_ready), 512'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst.stale", 512'(o_upd_valid), 512'd0);
            chk("mrst.full2", 512'(o_refill_buf_full), 512'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
